// File: rtl/pong_game_ctrl.sv
// ---------------------------------------------------------------------------
// pong_game_ctrl
//
// Game sequencer for Pong. It runs the START/SERVE/PLAY/DONE state machine,
// moves the ball once per video frame, bounces the ball off the top and
// bottom borders and off both paddles, detects misses, keeps both scores and
// declares the winner. The outputs feed the pixel generator directly.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   frame_tick   in   one-cycle pulse per frame (vertical blank)
//   enter        in   one-cycle debounced button pulse
//   posX1/posX2  in   [9:0] paddle left-edge bases (paddle h = posX+8..posX+18)
//   posY1/posY2  in   [8:0] paddle top bases       (paddle v = posY+8..posY+48)
//   ballX/ballY  out  [9:0] registered ball position (ball spans X..X+8)
//   score1/2     out  [1:0] registered scores
//   state        out  [1:0] START=00, SERVE=01, PLAY=10, DONE=11
//
// Build option
//   PONG_SPEEDUP_EN : when defined, every paddle hit raises the ball speed
//                     by 1 (saturating at 2*STEP); a miss, START or rst
//                     return it to STEP. When undefined the speed is the
//                     constant STEP and no speed register exists.
// ---------------------------------------------------------------------------
module pong_game_ctrl #(
  parameter int CENTER_X  = 316,
  parameter int CENTER_Y  = 236,
  parameter int STEP      = 2,
  parameter int WIN_SCORE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       enter,
  input  logic [9:0] posX1,
  input  logic [9:0] posX2,
  input  logic [8:0] posY1,
  input  logic [8:0] posY2,
  output logic [9:0] ballX,
  output logic [9:0] ballY,
  output logic [1:0] score1,
  output logic [1:0] score2,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    START = 2'b00,
    SERVE = 2'b01,
    PLAY  = 2'b10,
    DONE  = 2'b11
  } state_e;

  localparam logic [9:0] CX   = 10'(CENTER_X);
  localparam logic [9:0] CY   = 10'(CENTER_Y);
  localparam logic [9:0] SPD0 = 10'(STEP);
  localparam logic [1:0] WIN  = 2'(WIN_SCORE);

  state_e     state_q, state_d;
  logic [9:0] ballX_q, ballX_d;
  logic [9:0] ballY_q, ballY_d;
  logic       dirX_q, dirX_d;   // 1 = moving right (toward player 2)
  logic       dirY_q, dirY_d;   // 1 = moving down
  logic [1:0] score1_q, score1_d;
  logic [1:0] score2_q, score2_d;
  logic [9:0] speed;

`ifdef PONG_SPEEDUP_EN
  localparam logic [9:0] SPD_MAX = 10'(2 * STEP);
  logic [9:0] speed_q, speed_d;
  assign speed = speed_q;
`else
  assign speed = SPD0;
`endif

  // All geometry is compared in 11 bits so that +offsets never wrap.
  logic [10:0] bx, by, px1, px2, py1, py2, spd11;
  assign bx    = {1'b0, ballX_q};
  assign by    = {1'b0, ballY_q};
  assign px1   = {1'b0, posX1};
  assign px2   = {1'b0, posX2};
  assign py1   = {2'b00, posY1};
  assign py2   = {2'b00, posY2};
  assign spd11 = {1'b0, speed};

  // A paddle only counts when the ball is travelling toward it, which also
  // resolves the case where both paddle overlaps are true at once.
  logic hit1, hit2, hit, missL, missR, bounceTop, bounceBot;
  assign hit1 = !dirX_q && (bx <= px1 + 11'd18) && (bx + 11'd8 >= px1 + 11'd8) &&
                (by + 11'd8 >= py1 + 11'd8) && (by <= py1 + 11'd48);
  assign hit2 =  dirX_q && (bx <= px2 + 11'd18) && (bx + 11'd8 >= px2 + 11'd8) &&
                (by + 11'd8 >= py2 + 11'd8) && (by <= py2 + 11'd48);
  assign hit  = hit1 || hit2;
  assign missL = !hit && !dirX_q && (bx < spd11);
  assign missR = !hit &&  dirX_q && (bx + 11'd8 + spd11 > 11'd639);
  assign bounceTop = !dirY_q && (by <= 11'd8);
  assign bounceBot =  dirY_q && (by + 11'd8 >= 11'd471);

  // State register and all datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= START;
      ballX_q  <= CX;
      ballY_q  <= CY;
      dirX_q   <= 1'b1;
      dirY_q   <= 1'b1;
      score1_q <= 2'd0;
      score2_q <= 2'd0;
`ifdef PONG_SPEEDUP_EN
      speed_q  <= SPD0;
`endif
    end else begin
      state_q  <= state_d;
      ballX_q  <= ballX_d;
      ballY_q  <= ballY_d;
      dirX_q   <= dirX_d;
      dirY_q   <= dirY_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
`ifdef PONG_SPEEDUP_EN
      speed_q  <= speed_d;
`endif
    end
  end

  // Next-state and datapath update. A miss takes priority over any border
  // bounce; otherwise bounces update the directions and the move on the
  // same tick already uses the new directions.
  always_comb begin
    state_d  = state_q;
    ballX_d  = ballX_q;
    ballY_d  = ballY_q;
    dirX_d   = dirX_q;
    dirY_d   = dirY_q;
    score1_d = score1_q;
    score2_d = score2_q;
`ifdef PONG_SPEEDUP_EN
    speed_d  = speed_q;
`endif
    case (state_q)
      START: begin
        score1_d = 2'd0;
        score2_d = 2'd0;
        ballX_d  = CX;
        ballY_d  = CY;
`ifdef PONG_SPEEDUP_EN
        speed_d  = SPD0;
`endif
        if (enter) state_d = SERVE;
      end
      SERVE: begin
        ballX_d = CX;
        ballY_d = CY;
        if (enter) state_d = PLAY;
      end
      PLAY: begin
        if (frame_tick) begin
          if (missL || missR) begin
            ballX_d = CX;
            ballY_d = CY;
            dirX_d  = missR;
`ifdef PONG_SPEEDUP_EN
            speed_d = SPD0;
`endif
            if (missL) begin
              score2_d = score2_q + 2'd1;
              state_d  = (score2_q + 2'd1 == WIN) ? DONE : SERVE;
            end else begin
              score1_d = score1_q + 2'd1;
              state_d  = (score1_q + 2'd1 == WIN) ? DONE : SERVE;
            end
          end else begin
            if (bounceTop) dirY_d = 1'b1;
            if (bounceBot) dirY_d = 1'b0;
            if (hit1)      dirX_d = 1'b1;
            if (hit2)      dirX_d = 1'b0;
`ifdef PONG_SPEEDUP_EN
            if (hit) speed_d = (speed_q >= SPD_MAX) ? SPD_MAX : speed_q + 10'd1;
`endif
            ballX_d = dirX_d ? ballX_q + speed : ballX_q - speed;
            ballY_d = dirY_d ? ballY_q + speed : ballY_q - speed;
          end
        end
      end
      DONE: begin
        // Leaving DONE clears the board on the same edge so START shows 0-0.
        if (enter) begin
          state_d  = START;
          score1_d = 2'd0;
          score2_d = 2'd0;
          ballX_d  = CX;
          ballY_d  = CY;
`ifdef PONG_SPEEDUP_EN
          speed_d  = SPD0;
`endif
        end
      end
      default: state_d = START;
    endcase
  end

  // Outputs come straight from registers.
  always_comb begin
    state  = state_q;
    ballX  = ballX_q;
    ballY  = ballY_q;
    score1 = score1_q;
    score2 = score2_q;
  end

endmodule
